pwm_decoder: RTL and testbench

Recovers the duty level from a single-wire PWM signal: the receiving end of the LED-glow PWM generator. It synchronises an asynchronous `pwm_in`, measures high time and period between rising edges, and reports a saturated `LEVEL_W`-bit level equal to the generator's threshold. It detects stuck-low and stuck-high inputs (0 % and 100 % duty) by timeout. It serves loop-back self-test on the board, with generator output wired to a header and back in, and decoding of external PWM sources.

---
 rtl/pwm_decoder.sv | 85 ++++++++
 tb/tb_pwm_decoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers duty level, high time and period from an asynchronous PWM input,
// flagging stuck-low/stuck-high inputs by timeout.
module pwm_decoder #(
  parameter int LEVEL_W = 4,
  parameter int CNT_W   = 16,
  parameter int SHIFT   = 0,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwm_in,
  output logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   high_time,
  output logic [CNT_W-1:0]   period,
  output logic               valid,
  output logic               locked,
  output logic               stuck
);
  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, STUCK} state_t;
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
  localparam logic [LEVEL_W-1:0] LVL_MAX = {LEVEL_W{1'b1}};
  localparam logic [CNT_W-1:0]   TO      = CNT_W'(TIMEOUT);
  state_t state, state_nxt;
  logic s1, s2, p, p_d, rise, fall, measuring, capture, to_stuck, stuck_fall;
  logic [CNT_W-1:0] period_cnt, high_cnt, high_sh;
  logic [LEVEL_W-1:0] level_cap;
  assign p          = s2;
  assign rise       = p & ~p_d;
  assign fall       = ~p & p_d;
  assign measuring  = state == ARMED || state == LOCKED;
  assign high_sh    = high_cnt >> SHIFT;
  assign level_cap  = high_sh > CNT_W'(LVL_MAX) ? LVL_MAX : high_sh[LEVEL_W-1:0];
  assign locked     = state == LOCKED;
  assign stuck      = state == STUCK;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, p_d} <= '0;
    else     {s1, s2, p_d} <= {pwm_in, s1, s2};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else begin
      period_cnt <= rise ? CNT_W'(1) : period_cnt == CNT_MAX ? period_cnt : period_cnt + CNT_W'(1);
      high_cnt   <= rise ? CNT_W'(1) : (p && high_cnt != CNT_MAX) ? high_cnt + CNT_W'(1) : high_cnt;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  // a rise always wins over a coincident timeout
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    to_stuck   = 1'b0;
    stuck_fall = 1'b0;
    if (rise) begin
      capture   = measuring;
      state_nxt = measuring ? LOCKED : ARMED;
    end else if (state != STUCK && period_cnt == TO) begin
      to_stuck  = 1'b1;
      state_nxt = STUCK;
    end else begin
      stuck_fall = stuck && fall;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level     <= '0;
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= capture | to_stuck | stuck_fall;
      if (capture) begin
        level     <= level_cap;
        high_time <= high_cnt;
        period    <= period_cnt;
      end else if (to_stuck) begin
        level     <= p ? LVL_MAX : '0;
        high_time <= p ? period_cnt : '0;
      end else if (stuck_fall) begin
        level     <= '0;
        high_time <= '0;
      end
    end
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: two decoders (SHIFT=0/TIMEOUT=100 and SHIFT=2/TIMEOUT=1000) on one input,
// checked every cycle against an edge-timestamp model plus directed literal checks.
module tb_pwm_decoder;
  logic clk = 0, rst = 1, pwm_in = 0;
  logic [3:0] lvl0, lvl2;
  logic [15:0] hi0, hi2, per0, per2;
  logic v0, v2, lk0, lk2, st0, st2;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  pwm_decoder #(.LEVEL_W(4), .CNT_W(16), .SHIFT(0), .TIMEOUT(100)) dut0 (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .level(lvl0), .high_time(hi0),
    .period(per0), .valid(v0), .locked(lk0), .stuck(st0));
  pwm_decoder #(.LEVEL_W(4), .CNT_W(16), .SHIFT(2), .TIMEOUT(1000)) dut2 (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .level(lvl2), .high_time(hi2),
    .period(per2), .valid(v2), .locked(lk2), .stuck(st2));
  task automatic check(string name, longint got, longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  // model: mode 0 idle, 1 armed, 2 locked, 3 stuck; times are cycle stamps
  int c = 0;
  bit s1m = 0, pm = 0, pdm = 0;
  int anchor[2] = '{0, 0}, fall_t[2] = '{0, 0}, mode[2] = '{0, 0};
  bit fall_seen[2] = '{0, 0}, e_val[2] = '{0, 0};
  int e_lvl[2] = '{0, 0}, e_hi[2] = '{0, 0}, e_per[2] = '{0, 0};
  int vcnt0 = 0, vcnt2 = 0, vlast0 = 0, vgap0 = 0;
  task automatic model_step();
    bit rise, fall;
    int age, to, sh;
    if (rst) begin
      c = 0; s1m = 0; pm = 0; pdm = 0;
      for (int i = 0; i < 2; i++) begin
        anchor[i] = 0; mode[i] = 0; fall_seen[i] = 0;
        e_val[i] = 0; e_lvl[i] = 0; e_hi[i] = 0; e_per[i] = 0;
      end
      return;
    end
    rise = pm && !pdm;
    fall = !pm && pdm;
    for (int i = 0; i < 2; i++) begin
      to = i ? 1000 : 100;
      sh = i ? 2 : 0;
      age = c - anchor[i];
      e_val[i] = 0;
      if (rise) begin
        if (mode[i] == 1 || mode[i] == 2) begin
          e_per[i] = age;
          e_hi[i] = fall_seen[i] ? fall_t[i] - anchor[i] : age;
          e_lvl[i] = (e_hi[i] >> sh) > 15 ? 15 : e_hi[i] >> sh;
          e_val[i] = 1;
          mode[i] = 2;
        end else mode[i] = 1;
        anchor[i] = c;
        fall_seen[i] = 0;
      end else if (mode[i] != 3 && age == to) begin
        mode[i] = 3; e_val[i] = 1;
        e_lvl[i] = pm ? 15 : 0;
        e_hi[i] = pm ? age : 0;
      end else if (mode[i] == 3 && fall) begin
        e_val[i] = 1; e_lvl[i] = 0; e_hi[i] = 0;
      end
      if (fall) begin
        fall_seen[i] = 1;
        fall_t[i] = c;
      end
    end
    pdm = pm; pm = s1m; s1m = pwm_in; c++;
  endtask
  always @(posedge clk) begin
    model_step();
    #1;
    check($sformatf("cyc_dut0@%0d", c), 64'({lvl0, hi0, per0, v0, lk0, st0}),
          64'({4'(e_lvl[0]), 16'(e_hi[0]), 16'(e_per[0]), e_val[0], mode[0] == 2, mode[0] == 3}));
    check($sformatf("cyc_dut2@%0d", c), 64'({lvl2, hi2, per2, v2, lk2, st2}),
          64'({4'(e_lvl[1]), 16'(e_hi[1]), 16'(e_per[1]), e_val[1], mode[1] == 2, mode[1] == 3}));
    if (v0) begin vcnt0++; vgap0 = c - vlast0; vlast0 = c; end
    if (v2) vcnt2++;
  end
  task automatic run(int h, int p, int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) begin
        @(negedge clk);
        pwm_in = i < h;
      end
  endtask
  task automatic hold(bit v, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask
  initial begin
    int vc0, vc2;
    repeat (3) @(negedge clk);
    check("reset_outs0", {lvl0, hi0, per0, v0, lk0, st0}, 0);
    rst = 0;
    run(5, 16, 4);
    check("nom_vcnt", vcnt0, 3);
    check("nom_level", lvl0, 5);
    check("nom_high", hi0, 5);
    check("nom_period", per0, 16);
    check("nom_locked", lk0, 1);
    check("nom_gap", vgap0, 16);
    hold(0, 150);
    check("slow_stuck", st0, 1);
    check("slow_level", lvl0, 0);
    check("slow_locked", lk0, 0);
    check("slow_period", per0, 16);
    check("slow_dut2_nostuck", st2, 0);
    run(5, 16, 3);
    check("resume_locked", lk0, 1);
    check("resume_level", lvl0, 5);
    hold(1, 150);
    check("shigh_level", lvl0, 15);
    check("shigh_stuck", st0, 1);
    check("shigh_high", hi0, 100);
    check("shigh_locked", lk0, 0);
    vc0 = vcnt0;
    hold(0, 5);
    check("shigh_fall_valid", vcnt0, vc0 + 1);
    check("shigh_fall_level", lvl0, 0);
    check("shigh_fall_high", hi0, 0);
    run(5, 16, 2);
    run(5, 100, 3);
    check("bnd_period", per0, 100);
    check("bnd_nostuck", st0, 0);
    check("bnd_locked", lk0, 1);
    run(1, 2, 10);
    hold(0, 3);
    check("p2_level", lvl0, 1);
    check("p2_high", hi0, 1);
    check("p2_period", per0, 2);
    check("p2_gap", vgap0, 2);
    check("p2_level_sh2", lvl2, 0);
    run(90, 200, 2);
    check("sat_level", lvl2, 15);
    check("sat_high", hi2, 90);
    check("sat_period", per2, 200);
    check("sat_dut0_stuck", st0, 1);
    run(40, 200, 2);
    check("shift_level", lvl2, 10);
    check("shift_high", hi2, 40);
    check("shift_locked", lk2, 1);
    run(5, 16, 1);
    check("armed_locked", lk0, 0);
    check("armed_stuck", st0, 0);
    @(negedge clk);
    rst = 1;
    #1;
    check("midrst_outs0", {lvl0, hi0, per0, v0, lk0, st0}, 0);
    check("midrst_outs2", {lvl2, hi2, per2, v2, lk2, st2}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    vc0 = vcnt0;
    vc2 = vcnt2;
    run(5, 16, 1);
    check("post_rst_novalid0", vcnt0, vc0);
    check("post_rst_novalid2", vcnt2, vc2);
    run(5, 16, 2);
    check("post_rst_valid", vcnt0, vc0 + 2);
    check("post_rst_level", lvl0, 5);
    check("post_rst_locked", lk0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
